// File: rtl/mem_multi_bank_clr.sv
// -----------------------------------------------------------------------------
// mem_multi_bank_clr
//
// Multi-bank simple dual-port memory (one write port, one read port) with a
// bulk-clear engine that fills one bank, or every bank, with DEFAULT_VALUE at
// one word per cycle.
//
// Optional feature macro: MEM_MULTI_BANK_CLR_BYPASS_EN
//   defined   : a write (user or clear) landing on the bank/address being read
//               in the same cycle is forwarded, so the read returns new data.
//   undefined : read-first; the read returns the word as it was before that
//               write. No forwarding logic is built.
//
// Parameters
//   DATA_WIDTH    word width in bits
//   DEPTH         words per bank (>= 2)
//   NUM_BANKS     number of banks (>= 2, any count)
//   OUTPUT_DELAY  read latency in cycles, 1 or 2
//   DEFAULT_VALUE power-up contents and clear fill value
//   BANK_WIDTH    derived bank-select width, $clog2(NUM_BANKS)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   wea/banka/addra/dia         write port (dropped while a clear runs or when
//                               banka is not an existing bank)
//   reb/bankb/addrb             read port
//   dob/dob_valid               read data, valid for one cycle per read
//   clr_req/clr_all/clr_bank    bulk-clear request, all-banks select, target
//   clr_busy/clr_done           clear in progress, one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_multi_bank_clr #(
    parameter int          DATA_WIDTH    = 8,
    parameter int          DEPTH         = 64,
    parameter int          NUM_BANKS     = 4,
    parameter int          OUTPUT_DELAY  = 1,
    parameter int unsigned DEFAULT_VALUE = 0,
    localparam int         BANK_WIDTH    = $clog2(NUM_BANKS),
    localparam int         ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wea,
    input  logic [BANK_WIDTH-1:0] banka,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dia,
    input  logic                  reb,
    input  logic [BANK_WIDTH-1:0] bankb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] dob,
    output logic                  dob_valid,
    input  logic                  clr_req,
    input  logic                  clr_all,
    input  logic [BANK_WIDTH-1:0] clr_bank,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam logic [DATA_WIDTH-1:0] FILL = DATA_WIDTH'(DEFAULT_VALUE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // ------------------------------------------------------------------
    // Bank range checks. When NUM_BANKS fills the select width every code
    // is a real bank and the compare is dropped entirely.
    // ------------------------------------------------------------------
    logic wr_bank_ok;
    logic rd_bank_ok;

    generate
        if (NUM_BANKS == (1 << BANK_WIDTH)) begin : g_full_range
            assign wr_bank_ok = 1'b1;
            assign rd_bank_ok = 1'b1;
        end else begin : g_part_range
            assign wr_bank_ok = (banka < BANK_WIDTH'(NUM_BANKS));
            assign rd_bank_ok = (bankb < BANK_WIDTH'(NUM_BANKS));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_all_q, clr_all_d;
    logic [BANK_WIDTH-1:0] clr_bank_q, clr_bank_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_all_d  = clr_all_q;
        clr_bank_d = clr_bank_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    clr_all_d  = clr_all;
                    clr_bank_d = clr_bank;
                    cnt_d      = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_all_q  <= 1'b0;
            clr_bank_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_all_q  <= clr_all_d;
            clr_bank_q <= clr_bank_d;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = (state_q == DONE);

    // The clear write is suppressed in the reset cycle so an aborted clear
    // leaves the word at the counter untouched.
    logic clr_we;
    logic user_we;

    assign clr_we  = (state_q == CLEAR) && !reset;
    assign user_we = wea && !clr_busy && wr_bank_ok;

    // ------------------------------------------------------------------
    // Banks: one RAM array each, registered read enabled by reb.
    // A clear and a user write never coincide (user writes are blocked in
    // CLEAR), so the write address/data mux needs no arbitration.
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rd;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: FILL};
            logic [DATA_WIDTH-1:0] rd_q;
            logic                  we;
            logic [ADDR_WIDTH-1:0] waddr;
            logic [DATA_WIDTH-1:0] wdata;

            assign we    = (user_we && (banka == BANK_WIDTH'(gi))) ||
                           (clr_we && (clr_all_q || (clr_bank_q == BANK_WIDTH'(gi))));
            assign waddr = clr_we ? cnt_q : addra;
            assign wdata = clr_we ? FILL : dia;

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
                if (reb) begin
                    rd_q <= mem[addrb];
                end
            end

            assign bank_rd[gi] = rd_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read stage A: bank select and out-of-range flag travel alongside the
    // RAM output register. They only load on reb, so the selected word is
    // stable between reads and dob holds its value.
    // ------------------------------------------------------------------
    logic                  a_valid_q, a_valid_d;
    logic [BANK_WIDTH-1:0] sel_q, sel_d;
    logic                  oob_q, oob_d;
    logic [DATA_WIDTH-1:0] a_data;

`ifdef MEM_MULTI_BANK_CLR_BYPASS_EN
    logic                  fwd_hit_q, fwd_hit_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic                  hit_user;
    logic                  hit_clr;

    assign hit_user = user_we && (banka == bankb) && (addra == addrb);
    assign hit_clr  = clr_we && rd_bank_ok && (cnt_q == addrb) &&
                      (clr_all_q || (clr_bank_q == bankb));

    always_comb begin
        fwd_hit_d  = fwd_hit_q;
        fwd_data_d = fwd_data_q;
        if (reb) begin
            fwd_hit_d  = hit_user || hit_clr;
            fwd_data_d = hit_clr ? FILL : dia;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end
`endif

    always_comb begin
        a_valid_d = reb;
        sel_d     = reb ? bankb : sel_q;
        oob_d     = reb ? !rd_bank_ok : oob_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            sel_q     <= '0;
            oob_q     <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            sel_q     <= sel_d;
            oob_q     <= oob_d;
        end
    end

    always_comb begin
        a_data = FILL;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (sel_q == BANK_WIDTH'(i)) begin
                a_data = bank_rd[i];
            end
        end
        if (oob_q) begin
            a_data = FILL;
        end
`ifdef MEM_MULTI_BANK_CLR_BYPASS_EN
        if (fwd_hit_q) begin
            a_data = fwd_data_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (OUTPUT_DELAY == 2) begin : g_dly2
            logic [DATA_WIDTH-1:0] dob_q, dob_d;
            logic                  dob_valid_q, dob_valid_d;

            always_comb begin
                dob_d       = a_valid_q ? a_data : dob_q;
                dob_valid_d = a_valid_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dob_q       <= '0;
                    dob_valid_q <= 1'b0;
                end else begin
                    dob_q       <= dob_d;
                    dob_valid_q <= dob_valid_d;
                end
            end

            assign dob       = dob_q;
            assign dob_valid = dob_valid_q;
        end else begin : g_dly1
            // Stage A is the output. seen_q forces dob to zero from reset
            // until the first read lands, since the RAM registers are not
            // reset.
            logic seen_q, seen_d;

            always_comb begin
                seen_d = seen_q | reb;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    seen_q <= 1'b0;
                end else begin
                    seen_q <= seen_d;
                end
            end

            assign dob       = seen_q ? a_data : '0;
            assign dob_valid = a_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_mem_multi_bank_clr.sv
// -----------------------------------------------------------------------------
// tb_mem_multi_bank_clr
//
// Two instances share one stimulus stream:
//   u_dut0 : NUM_BANKS=3, OUTPUT_DELAY=2 (bank code 3 is out of range)
//   u_dut1 : NUM_BANKS=4, OUTPUT_DELAY=1 (bank code 3 is a real bank)
// Each read pushes the hand-computed word and due cycle for each instance into
// its queue; a monitor pops and compares whenever dob_valid is seen and flags
// reads that never complete or completions nobody asked for.
// -----------------------------------------------------------------------------
module tb_mem_multi_bank_clr;

    localparam int DW = 8;
    localparam int BW = 2;
    localparam int AW = 6;

`ifdef MEM_MULTI_BANK_CLR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wea = 1'b0;
    logic [BW-1:0] banka = '0;
    logic [AW-1:0] addra = '0;
    logic [DW-1:0] dia = '0;
    logic          reb = 1'b0;
    logic [BW-1:0] bankb = '0;
    logic [AW-1:0] addrb = '0;
    logic          clr_req = 1'b0;
    logic          clr_all = 1'b0;
    logic [BW-1:0] clr_bank = '0;

    logic [DW-1:0] dob0, dob1;
    logic          dob_valid0, dob_valid1;
    logic          clr_busy0, clr_busy1;
    logic          clr_done0, clr_done1;

    always #5 clk = ~clk;

    mem_multi_bank_clr #(
        .DATA_WIDTH(DW), .DEPTH(64), .NUM_BANKS(3), .OUTPUT_DELAY(2), .DEFAULT_VALUE(0)
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .wea(wea), .banka(banka), .addra(addra), .dia(dia),
        .reb(reb), .bankb(bankb), .addrb(addrb),
        .dob(dob0), .dob_valid(dob_valid0),
        .clr_req(clr_req), .clr_all(clr_all), .clr_bank(clr_bank),
        .clr_busy(clr_busy0), .clr_done(clr_done0)
    );

    mem_multi_bank_clr #(
        .DATA_WIDTH(DW), .DEPTH(64), .NUM_BANKS(4), .OUTPUT_DELAY(1), .DEFAULT_VALUE(0)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .wea(wea), .banka(banka), .addra(addra), .dia(dia),
        .reb(reb), .bankb(bankb), .addrb(addrb),
        .dob(dob1), .dob_valid(dob_valid1),
        .clr_req(clr_req), .clr_all(clr_all), .clr_bank(clr_bank),
        .clr_busy(clr_busy1), .clr_done(clr_done1)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        string         name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy0 = 0, busy1 = 0, done0 = 0, done1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic mon(input int which, input logic dv, input logic [DW-1:0] d);
        exp_t e;
        int   sz;
        sz = (which == 0) ? q0.size() : q1.size();
        if (dv === 1'b1) begin
            if (sz == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d stray dob_valid at cycle %0d: got dob=0x%0h, required no read outstanding",
                         which, cyc, d);
            end else begin
                if (which == 0) e = q0.pop_front();
                else            e = q1.pop_front();
                check($sformatf("dut%0d %s cycle", which, e.name), cyc, e.due);
                check($sformatf("dut%0d %s data", which, e.name), d, e.data);
            end
        end else if (sz > 0) begin
            e = (which == 0) ? q0[0] : q1[0];
            if (e.due <= cyc) begin
                if (which == 0) void'(q0.pop_front());
                else            void'(q1.pop_front());
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d %s missing: got dob_valid=0 at cycle %0d, required 1 at cycle %0d",
                         which, e.name, cyc, e.due);
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            mon(0, dob_valid0, dob0);
            mon(1, dob_valid1, dob1);
            if (clr_busy0 === 1'b1) busy0++;
            if (clr_busy1 === 1'b1) busy1++;
            if (clr_done0 === 1'b1) done0++;
            if (clr_done1 === 1'b1) done1++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int b, input int a, input int d);
        wea   = 1'b1;
        banka = b[BW-1:0];
        addra = a[AW-1:0];
        dia   = d[DW-1:0];
        cycle();
        wea   = 1'b0;
    endtask

    // Issue one read; e0/e1 are the words dut0/dut1 must return.
    task automatic rd(input int b, input int a, input logic [DW-1:0] e0,
                      input logic [DW-1:0] e1, input string nm);
        reb   = 1'b1;
        bankb = b[BW-1:0];
        addrb = a[AW-1:0];
        q0.push_back('{due: cyc + 2, data: e0, name: nm});
        q1.push_back('{due: cyc + 1, data: e1, name: nm});
        cycle();
        reb = 1'b0;
    endtask

    initial begin
        int b0s, b1s, d0s, d1s;
        int alist[4];
        logic [DW-1:0] e;

        // ---------------- reset state ----------------
        repeat (3) cycle();
        reset = 1'b0;
        check("dut0 reset dob", dob0, 0);
        check("dut0 reset dob_valid", dob_valid0, 0);
        check("dut0 reset clr_busy", clr_busy0, 0);
        check("dut0 reset clr_done", clr_done0, 0);
        check("dut1 reset dob", dob1, 0);
        check("dut1 reset dob_valid", dob_valid1, 0);

        // ---------------- reset flushes an in-flight read ----------------
        // dut1 (latency 1) completes before reset; dut0 (latency 2) must not.
        reb = 1'b1; bankb = 2'd0; addrb = '0;
        q1.push_back('{due: cyc + 1, data: 8'h00, name: "pre-reset read"});
        cycle();
        reb   = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("dut0 dob_valid after flush", dob_valid0, 0);
        repeat (3) cycle();

        // ---------------- fill ----------------
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++)
                wr(b, a, 8'hFF);
        wr(2, 5, 8'hA5);
        wr(1, 3, 8'h11);

        // ---------------- basic read latency ----------------
        rd(2, 5, 8'hA5, 8'hA5, "b2a5 read");
        rd(0, 0, 8'hFF, 8'hFF, "b0a0 read");

        // ---------------- same-cycle read/write ----------------
        e = BYP ? 8'h22 : 8'h11;
        reb = 1'b1; bankb = 2'd1; addrb = 6'd3;
        wea = 1'b1; banka = 2'd1; addra = 6'd3; dia = 8'h22;
        q0.push_back('{due: cyc + 2, data: e, name: "b1a3 rd+wr"});
        q1.push_back('{due: cyc + 1, data: e, name: "b1a3 rd+wr"});
        cycle();
        reb = 1'b0; wea = 1'b0;
        rd(1, 3, 8'h22, 8'h22, "b1a3 after write");

        // ---------------- bank code 3 ----------------
        rd(3, 0, 8'h00, 8'hFF, "b3a0 read");
        wr(3, 7, 8'h5A);
        rd(3, 7, 8'h00, 8'h5A, "b3a7 after write");
        rd(0, 7, 8'hFF, 8'hFF, "b0a7 untouched");
        rd(1, 7, 8'hFF, 8'hFF, "b1a7 untouched");
        rd(2, 7, 8'hFF, 8'hFF, "b2a7 untouched");

        // ---------------- single-bank clear of bank 1 ----------------
        b0s = busy0; b1s = busy1; d0s = done0; d1s = done1;
        clr_req = 1'b1; clr_all = 1'b0; clr_bank = 2'd1;
        cycle();
        clr_req = 1'b0;
        check("dut0 clr_busy after request", clr_busy0, 1);
        repeat (80) cycle();
        check("dut0 bank1 clear busy cycles", busy0 - b0s, 64);
        check("dut1 bank1 clear busy cycles", busy1 - b1s, 64);
        check("dut0 bank1 clear done pulses", done0 - d0s, 1);
        check("dut1 bank1 clear done pulses", done1 - d1s, 1);
        rd(1, 0, 8'h00, 8'h00, "b1a0 cleared");
        rd(1, 3, 8'h00, 8'h00, "b1a3 cleared");
        rd(1, 63, 8'h00, 8'h00, "b1a63 cleared");
        rd(0, 0, 8'hFF, 8'hFF, "b0a0 kept");
        rd(2, 5, 8'hA5, 8'hA5, "b2a5 kept");
        rd(2, 63, 8'hFF, 8'hFF, "b2a63 kept");
        rd(3, 0, 8'h00, 8'hFF, "b3a0 kept");

        // ---------------- write and request during CLEAR ----------------
        b0s = busy0; b1s = busy1; d0s = done0; d1s = done1;
        clr_req = 1'b1; clr_all = 1'b0; clr_bank = 2'd0;
        cycle();
        clr_req = 1'b0;
        repeat (5) cycle();
        // counter is 5 here: addresses 0..4 of bank 0 already cleared
        wea = 1'b1; banka = 2'd2; addra = 6'd10; dia = 8'h77;
        clr_req = 1'b1; clr_all = 1'b1; clr_bank = 2'd2;
        reb = 1'b1; bankb = 2'd0; addrb = 6'd2;
        q0.push_back('{due: cyc + 2, data: 8'h00, name: "b0a2 mid-clear"});
        q1.push_back('{due: cyc + 1, data: 8'h00, name: "b0a2 mid-clear"});
        cycle();
        wea = 1'b0; clr_req = 1'b0; clr_all = 1'b0;
        addrb = 6'd60;
        q0.push_back('{due: cyc + 2, data: 8'hFF, name: "b0a60 mid-clear"});
        q1.push_back('{due: cyc + 1, data: 8'hFF, name: "b0a60 mid-clear"});
        cycle();
        reb = 1'b0;
        repeat (80) cycle();
        check("dut0 busy with ignored request", busy0 - b0s, 64);
        check("dut1 busy with ignored request", busy1 - b1s, 64);
        check("dut0 done with ignored request", done0 - d0s, 1);
        check("dut1 done with ignored request", done1 - d1s, 1);
        rd(2, 10, 8'hFF, 8'hFF, "b2a10 write dropped");
        rd(0, 10, 8'h00, 8'h00, "b0a10 cleared");
        rd(0, 63, 8'h00, 8'h00, "b0a63 cleared");
        rd(3, 10, 8'h00, 8'hFF, "b3a10 not cleared");

        // ---------------- reset aborts clear-all at cycle 10 ----------------
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++)
                wr(b, a, 8'h80 | a);
        d0s = done0; d1s = done1;
        clr_req = 1'b1; clr_all = 1'b1; clr_bank = 2'd0;
        cycle();
        clr_req = 1'b0; clr_all = 1'b0;
        repeat (10) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("dut0 clr_busy after abort", clr_busy0, 0);
        check("dut1 clr_busy after abort", clr_busy1, 0);
        repeat (70) cycle();
        check("dut0 no done after abort", done0 - d0s, 0);
        check("dut1 no done after abort", done1 - d1s, 0);
        alist[0] = 0; alist[1] = 9; alist[2] = 10; alist[3] = 63;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                logic [DW-1:0] x1, x0;
                x1 = (alist[k] < 10) ? 8'h00 : (8'h80 | 8'(alist[k]));
                x0 = (b == 3) ? 8'h00 : x1;
                rd(b, alist[k], x0, x1, $sformatf("abort b%0da%0d", b, alist[k]));
            end
        end

        // ---------------- drain ----------------
        repeat (5) cycle();
        check("dut0 reads outstanding", q0.size(), 0);
        check("dut1 reads outstanding", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_multi_bank_clr.md
MEM_MULTI_BANK_CLR -- requirements
Module: mem_multi_bank_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: words per bank, at least 2.
REQ-003 SHALL have parameter NUM_BANKS, default 4: bank count, at least 2, power of two not required.
REQ-004 SHALL have parameter OUTPUT_DELAY, default 1: read latency in cycles, 1 or 2 only.
REQ-005 SHALL have parameter DEFAULT_VALUE, default 0: memory init value and clear fill value.
REQ-006 SHALL have derived parameter BANK_WIDTH = $clog2(NUM_BANKS).
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have ports wea / banka / addra / dia, input, 1 / BANK_WIDTH / $clog2(DEPTH) / DATA_WIDTH bits: write port.
REQ-010 SHALL have ports reb / bankb / addrb, input, 1 / BANK_WIDTH / $clog2(DEPTH) bits: read port.
REQ-011 SHALL have port dob, output, DATA_WIDTH bits: read data.
REQ-012 SHALL have port dob_valid, output, 1 bit: dob holds the result of a read.
REQ-013 SHALL have ports clr_req / clr_all / clr_bank, input, 1 / 1 / BANK_WIDTH bits: bulk-clear request, all-banks select, target bank.
REQ-014 SHALL have ports clr_busy / clr_done, output, 1 bit each: clear in progress; one-cycle completion pulse.

Function
REQ-015 SHALL write dia to banka/addra at the clk edge when wea=1, clr_busy=0 and banka<NUM_BANKS; all other writes are dropped.
REQ-016 SHALL present read data on dob, and assert dob_valid for one cycle, exactly OUTPUT_DELAY cycles after the reb=1 cycle.
REQ-017 SHALL hold dob at its last value when no read completes.
REQ-018 SHALL return DEFAULT_VALUE for a read with bankb>=NUM_BANKS, with dob_valid still asserted.
REQ-019 SHALL use clear FSM states IDLE, CLEAR and DONE.
REQ-020 SHALL, on clr_req=1 in IDLE, latch clr_all/clr_bank, zero the address counter and enter CLEAR.
REQ-021 SHALL, in CLEAR, write DEFAULT_VALUE to counter address in the latched bank, or in every bank if clr_all=1, and increment the counter each cycle.
REQ-022 SHALL go CLEAR -> DONE after writing address DEPTH-1, then DONE -> IDLE unconditionally.
REQ-023 SHALL make a clear occupy exactly DEPTH cycles with clr_busy=1 in CLEAR, and assert clr_done=1 only in DONE.
REQ-024 SHALL ignore clr_req in CLEAR or DONE; a request is not queued.
REQ-025 SHALL make a clear with latched clr_all=0 and clr_bank>=NUM_BANKS a no-op that still runs its full DEPTH cycles.
REQ-026 SHALL not stall reads during a clear; they return current contents, which are partially cleared.
REQ-027 SHALL return pre-write data for a same-cycle read and write to the same bank/addr (read-first) when the bypass feature is compiled out.

Reset
REQ-028 SHALL, on reset=1 at the clk edge, set the FSM to IDLE, the counter to 0, dob to 0, and dob_valid, clr_busy and clr_done to 0.
REQ-029 SHALL flush the read pipeline on reset, so no dob_valid follows a pre-reset read.
REQ-030 SHALL abort a clear hit by reset mid-operation without a clr_done pulse; cleared words stay cleared and the rest are unchanged.
REQ-031 SHALL leave memory contents unaffected by reset.

Configuration
REQ-032 SHALL, with macro MEM_MULTI_BANK_CLR_BYPASS_EN defined, forward a same-cycle write to the same bank/addr (user write or clear write) to the read: dob returns the new data after OUTPUT_DELAY cycles.
REQ-033 SHALL, with MEM_MULTI_BANK_CLR_BYPASS_EN undefined, use read-first behaviour per REQ-027 and contain no forwarding logic.

Verification
REQ-034 SHALL cover: OUTPUT_DELAY=2, write 0xA5 to bank 2 addr 5, then read at T -> dob=0xA5 with dob_valid=1 at T+2 only.
REQ-035 SHALL cover: memory holds 0x11 at bank 1 addr 3, same-cycle read plus write of 0x22 there -> 0x22 with bypass, 0x11 without.
REQ-036 SHALL cover: DEPTH=64, fill all banks with 0xFF, clr_req with clr_all=0, clr_bank=1 -> clr_busy=1 for 64 cycles, clr_done one pulse, bank 1 reads DEFAULT_VALUE, other banks read 0xFF.
REQ-037 SHALL cover: wea=1 and a second clr_req during CLEAR -> write dropped, second request ignored, exactly one clr_done.
REQ-038 SHALL cover: reset at clear cycle 10 with clr_all=1 -> no clr_done; addrs 0-9 read DEFAULT_VALUE, addrs 10-63 read the old data.
REQ-039 SHALL cover: NUM_BANKS=3, read bankb=3 -> DEFAULT_VALUE with dob_valid=1; write banka=3 -> no bank modified.
